// File: rtl/divisor_pkg.sv
// divisor_pkg: shared FSM states and two's-complement helpers for the divider
package divisor_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, FIN} estado_t;
  function automatic logic [63:0] neg(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction
  function automatic logic [63:0] abs_val(input logic [63:0] x, input int w);
    return x[w-1] ? neg(x) : x;
  endfunction
endpackage

// File: rtl/divisor_paso.sv
// divisor_paso: one combinational restoring-division step on {R,Q}
module divisor_paso #(
  parameter int W = 32
) (
  input  logic [W-1:0] r_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] r_o,
  output logic [W-1:0] q_o
);
  logic [W:0] sh, dif;
  assign sh  = {r_i, q_i[W-1]};
  assign dif = sh - {1'b0, d_i};
  assign r_o = dif[W] ? sh[W-1:0] : dif[W-1:0];
  assign q_o = {q_i[W-2:0], ~dif[W]};
endmodule

// File: rtl/divisor_multimodo.sv
// divisor_multimodo: iterative signed/unsigned restoring divider, one quotient bit per clock
module divisor_multimodo
  import divisor_pkg::*;
#(
  parameter int tamanyo = 32,
  parameter int CNT_W   = $clog2(tamanyo + 1)
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               Start,
  input  logic               Signo,
  input  logic [tamanyo-1:0] Num,
  input  logic [tamanyo-1:0] Den,
  output logic [tamanyo-1:0] Coc,
  output logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic               Busy,
  output logic               DivCero,
  output logic               Desb
);
  localparam logic [tamanyo-1:0] MIN = {1'b1, {(tamanyo-1){1'b0}}};
  estado_t estado_q, estado_d;
  logic [tamanyo-1:0] r_q, r_d, q_q, q_d, d_q, d_d, coc_q, coc_d, res_q, res_d, r_paso, q_paso;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signo_q, signo_d, sq_q, sq_d, sr_q, sr_d, dz_q, dz_d, ov_q, ov_d;

  divisor_paso #(.W(tamanyo)) u_paso (
    .r_i(r_q), .q_i(q_q), .d_i(d_q), .r_o(r_paso), .q_o(q_paso)
  );

  // state and datapath registers; reset clears everything so every output reads 0
  always_ff @(posedge CLK) begin
    if (RSTa) begin
      estado_q <= IDLE;
      r_q <= '0; q_q <= '0; d_q <= '0; coc_q <= '0; res_q <= '0; cnt_q <= '0;
      signo_q <= 1'b0; sq_q <= 1'b0; sr_q <= 1'b0; dz_q <= 1'b0; ov_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      r_q <= r_d; q_q <= q_d; d_q <= d_d; coc_q <= coc_d; res_q <= res_d; cnt_q <= cnt_d;
      signo_q <= signo_d; sq_q <= sq_d; sr_q <= sr_d; dz_q <= dz_d; ov_q <= ov_d;
    end
  end

  // next state: q/d hold the raw operands until LOAD turns them into magnitudes;
  // flagged results are parked in q/r and flow through FIX unchanged to keep the 3-edge latency
  always_comb begin
    estado_d = estado_q;
    r_d = r_q; q_d = q_q; d_d = d_q; coc_d = coc_q; res_d = res_q; cnt_d = cnt_q;
    signo_d = signo_q; sq_d = sq_q; sr_d = sr_q; dz_d = dz_q; ov_d = ov_q;
    case (estado_q)
      IDLE: if (Start) begin
        estado_d = LOAD; q_d = Num; d_d = Den; signo_d = Signo; dz_d = 1'b0; ov_d = 1'b0;
      end
      LOAD: begin
        estado_d = FIX; r_d = '0; cnt_d = '0; sq_d = 1'b0; sr_d = 1'b0;
        if (d_q == '0) begin
          q_d = '1; r_d = q_q; dz_d = 1'b1;
        end else if (signo_q && q_q == MIN && d_q == '1) begin
          ov_d = 1'b1;
        end else begin
          estado_d = ITER;
          q_d = signo_q ? tamanyo'(abs_val(64'(q_q), tamanyo)) : q_q;
          d_d = signo_q ? tamanyo'(abs_val(64'(d_q), tamanyo)) : d_q;
          sq_d = signo_q & (q_q[tamanyo-1] ^ d_q[tamanyo-1]);
          sr_d = signo_q & q_q[tamanyo-1];
        end
      end
      ITER: begin
        r_d = r_paso; q_d = q_paso; cnt_d = cnt_q + CNT_W'(1);
        estado_d = (cnt_q == CNT_W'(tamanyo - 1)) ? FIX : ITER;
      end
      FIX: begin
        coc_d = sq_q ? tamanyo'(neg(64'(q_q))) : q_q;
        res_d = sr_q ? tamanyo'(neg(64'(r_q))) : r_q;
        estado_d = FIN;
      end
      FIN: estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
  end

  assign Coc     = coc_q;
  assign Res     = res_q;
  assign Done    = estado_q == FIN;
  assign Busy    = estado_q == LOAD || estado_q == ITER || estado_q == FIX;
  assign DivCero = dz_q;
  assign Desb    = ov_q;
endmodule
